// File: rtl/id_scan_pkg.sv
// Shared types and helpers for the ID scanner: FSM encoding, empty-slot ID, slot width helper.
package id_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_NEXT = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  localparam logic [31:0] EMPTY_ID_DEF = 32'h0000_0000;

  // Smallest index width w with 2**w >= n (at least 1).
  function automatic int slot_w_for(input int n);
    int w;
    int p;
    w = 32'sd1;
    p = 32'sd2;
    for (int i = 0; i < 16; i++) begin
      if (p < n) begin
        p = p * 32'sd2;
        w = w + 32'sd1;
      end else begin
        p = p;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/id_scanner_table.sv
// id_table: N_SLOTS x SIZE_REG ID register file with one write port and a combinational read port.
// With ID_SCAN_MATCH_EN defined it also produces the registered per-slot match mask.
module id_table
  import id_scan_pkg::*;
#(
  parameter int                  SIZE_REG = 32,
  parameter int                  N_SLOTS  = 8,
  parameter int                  SLOT_W   = 3,
  parameter logic [SIZE_REG-1:0] EMPTY_ID = SIZE_REG'(EMPTY_ID_DEF)
) (
  input  logic                i_clk,
  input  logic                i_rst_a,
  input  logic                i_clr,
  input  logic                i_we,
  input  logic [SLOT_W-1:0]   i_waddr,
  input  logic [SIZE_REG-1:0] i_wdata,
  input  logic [SLOT_W-1:0]   i_raddr,
  output logic [SIZE_REG-1:0] o_rdata
`ifdef ID_SCAN_MATCH_EN
  ,
  input  logic [SIZE_REG-1:0] i_match_id,
  input  logic [N_SLOTS-1:0]  i_found_mask,
  output logic [N_SLOTS-1:0]  o_match_mask
`endif
);

  logic [SIZE_REG-1:0] r_mem [N_SLOTS];

  // Table storage: async reset and sync clear both return entries to EMPTY_ID.
  always_ff @(posedge i_clk or posedge i_rst_a) begin
    if (i_rst_a) begin
      for (int i = 0; i < N_SLOTS; i++) r_mem[i] <= EMPTY_ID;
    end else if (i_clr) begin
      for (int i = 0; i < N_SLOTS; i++) r_mem[i] <= EMPTY_ID;
    end else if (i_we) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        if (i_waddr == SLOT_W'(i)) r_mem[i] <= i_wdata;
      end
    end
  end

  // Read port: indices past the last slot read as EMPTY_ID.
  always_comb begin
    o_rdata = EMPTY_ID;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (i_raddr == SLOT_W'(i)) o_rdata = r_mem[i];
      else o_rdata = o_rdata;
    end
  end

`ifdef ID_SCAN_MATCH_EN
  logic [N_SLOTS-1:0] r_match;

  // Match mask follows table/match_id changes with one cycle of latency.
  always_ff @(posedge i_clk or posedge i_rst_a) begin
    if (i_rst_a) begin
      r_match <= '0;
    end else begin
      for (int i = 0; i < N_SLOTS; i++) begin
        r_match[i] <= i_found_mask[i] && (r_mem[i] == i_match_id);
      end
    end
  end

  assign o_match_mask = r_match;
`endif

endmodule

// File: rtl/id_scanner.sv
// id_scanner: master-side enumerator that reads every slot's ID register into a local table.
// Optional feature macro ID_SCAN_MATCH_EN adds match_id / match_mask.
module id_scanner
  import id_scan_pkg::*;
#(
  parameter int                  SIZE_REG    = 32,
  parameter int                  N_SLOTS     = 8,
  parameter int                  SLOT_W      = slot_w_for(N_SLOTS),
  parameter int                  TIMEOUT_CYC = 16,
  parameter logic [SIZE_REG-1:0] EMPTY_ID    = SIZE_REG'(EMPTY_ID_DEF)
) (
  input  logic                clk,
  input  logic                rst_a,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                rd_req,
  output logic [SLOT_W-1:0]   rd_slot,
  input  logic                rd_ack,
  input  logic [SIZE_REG-1:0] rd_data,
  output logic [N_SLOTS-1:0]  found_mask,
  output logic [N_SLOTS-1:0]  timeout_mask,
  input  logic [SLOT_W-1:0]   q_slot,
  output logic [SIZE_REG-1:0] q_id
`ifdef ID_SCAN_MATCH_EN
  ,
  input  logic [SIZE_REG-1:0] match_id,
  output logic [N_SLOTS-1:0]  match_mask
`endif
);

  state_t              r_state, w_state_nxt;
  logic [SLOT_W-1:0]   r_slot, w_slot_nxt;
  logic [7:0]          r_cnt, w_cnt_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_rd_req, w_rd_req_nxt;
  logic [N_SLOTS-1:0]  r_found, w_found_nxt;
  logic [N_SLOTS-1:0]  r_timeout, w_timeout_nxt;
  logic [N_SLOTS-1:0]  w_slot_oh;
  logic                w_tbl_clr;
  logic                w_tbl_we;

  always_comb begin
    w_slot_oh = '0;
    for (int i = 0; i < N_SLOTS; i++) w_slot_oh[i] = (r_slot == SLOT_W'(i));
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      r_state   <= ST_IDLE;
      r_slot    <= '0;
      r_cnt     <= 8'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_req  <= 1'b0;
      r_found   <= '0;
      r_timeout <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_slot    <= w_slot_nxt;
      r_cnt     <= w_cnt_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_rd_req  <= w_rd_req_nxt;
      r_found   <= w_found_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // Next-state logic; rd_req is registered by raising it on every transition into REQ.
  always_comb begin
    w_state_nxt   = r_state;
    w_slot_nxt    = r_slot;
    w_cnt_nxt     = r_cnt;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_rd_req_nxt  = 1'b0;
    w_found_nxt   = r_found;
    w_timeout_nxt = r_timeout;
    w_tbl_clr     = 1'b0;
    w_tbl_we      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // The done cycle itself is still too early to accept a new start.
        if (start && !r_done) begin
          w_tbl_clr     = 1'b1;
          w_found_nxt   = '0;
          w_timeout_nxt = '0;
          w_slot_nxt    = '0;
          w_busy_nxt    = 1'b1;
          w_rd_req_nxt  = 1'b1;
          w_state_nxt   = ST_REQ;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        w_cnt_nxt   = 8'd0;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (rd_ack) begin
          w_tbl_we    = 1'b1;
          w_found_nxt = (rd_data != EMPTY_ID) ? (r_found | w_slot_oh) : r_found;
          w_state_nxt = ST_NEXT;
        end else if (r_cnt == 8'(TIMEOUT_CYC - 1)) begin
          w_timeout_nxt = r_timeout | w_slot_oh;
          w_state_nxt   = ST_NEXT;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      ST_NEXT: begin
        if (r_slot == SLOT_W'(N_SLOTS - 1)) begin
          w_state_nxt = ST_FIN;
        end else begin
          w_slot_nxt   = r_slot + SLOT_W'(1);
          w_rd_req_nxt = 1'b1;
          w_state_nxt  = ST_REQ;
        end
      end
      ST_FIN: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  id_table #(
    .SIZE_REG (SIZE_REG),
    .N_SLOTS  (N_SLOTS),
    .SLOT_W   (SLOT_W),
    .EMPTY_ID (EMPTY_ID)
  ) u_table (
    .i_clk        (clk),
    .i_rst_a      (rst_a),
    .i_clr        (w_tbl_clr),
    .i_we         (w_tbl_we),
    .i_waddr      (r_slot),
    .i_wdata      (rd_data),
    .i_raddr      (q_slot),
    .o_rdata      (q_id)
`ifdef ID_SCAN_MATCH_EN
    ,
    .i_match_id   (match_id),
    .i_found_mask (r_found),
    .o_match_mask (match_mask)
`endif
  );

  assign busy         = r_busy;
  assign done         = r_done;
  assign rd_req       = r_rd_req;
  assign rd_slot      = r_slot;
  assign found_mask   = r_found;
  assign timeout_mask = r_timeout;

endmodule
